// File: rtl/multicycle_sequencer_if.sv
// Handshake and control bundle between the multicycle sequencer and its datapath/memory.
// Latency: none (wires only).
// Backpressure: MemAck is the only flow-control signal; MemReq stays high until it arrives or times out.
//
// Ports:
//   master - drives Start/Opcode/DecodeBus/AluEq/AluGt/MemAck, observes sequencer outputs
//   slave  - the sequencer side: consumes the inputs above, drives strobes, State, flags, InstrCount
interface multicycle_sequencer_if #(
    parameter int CNT_W = 32
);
    logic             Start;
    logic [4:0]       Opcode;
    logic [7:0]       DecodeBus;
    logic             AluEq;
    logic             AluGt;
    logic             MemAck;
    logic             MemReq;
    logic             MemWe;
    logic             IrWrite;
    logic             PcWrite;
    logic [1:0]       PcSel;
    logic             RegWrite;
    logic [2:0]       State;
    logic             Halted;
    logic             Error;
    logic [CNT_W-1:0] InstrCount;

    modport master (
        output Start, Opcode, DecodeBus, AluEq, AluGt, MemAck,
        input  MemReq, MemWe, IrWrite, PcWrite, PcSel, RegWrite,
               State, Halted, Error, InstrCount
    );

    modport slave (
        input  Start, Opcode, DecodeBus, AluEq, AluGt, MemAck,
        output MemReq, MemWe, IrWrite, PcWrite, PcSel, RegWrite,
               State, Halted, Error, InstrCount
    );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multicycle instruction sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK control with retire counting.
// Latency: 3 cycles minimum per instruction plus memory wait cycles; IrWrite and memory-side PcWrite follow MemAck combinationally.
// Backpressure: waits in FETCH/MEMORY for MemAck up to TIMEOUT cycles, then halts with a sticky Error.
//
// Ports:
//   clk     - single clock, rising edge
//   reset_n - asynchronous active-low reset, returns to IDLE with all strobes low
//   bus     - multicycle_sequencer_if.slave: instruction/decode/ALU/memory inputs, control strobes and status outputs
module multicycle_sequencer #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 32
) (
    input  logic                        clk,
    input  logic                        reset_n,
    multicycle_sequencer_if.slave       bus
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_HALT      = 3'd6
    } state_t;

    localparam logic [4:0] TIMEOUT_LIM = 5'(TIMEOUT);
    localparam logic [4:0] OP_CMP      = 5'b00101;
    localparam logic [4:0] OP_FIRST_BAD = 5'b10101;

    state_t           r_state;
    logic [3:0]       r_wait;
    logic             r_flag_e;
    logic             r_flag_gt;
    logic             r_error;
    logic [CNT_W-1:0] r_instr_cnt;

    logic w_is_wb, w_is_call, w_is_ubr, w_is_ret, w_is_bgt, w_is_beq, w_is_ld, w_is_st;
    logic w_to_wb;
    logic w_to_mem;
    logic w_taken;
    logic w_retire;
    logic w_wait_hit;

    assign w_is_wb   = bus.DecodeBus[7];
    assign w_is_call = bus.DecodeBus[6];
    assign w_is_ubr  = bus.DecodeBus[5];
    assign w_is_ret  = bus.DecodeBus[4];
    assign w_is_bgt  = bus.DecodeBus[3];
    assign w_is_beq  = bus.DecodeBus[2];
    assign w_is_ld   = bus.DecodeBus[1];
    assign w_is_st   = bus.DecodeBus[0];

    // A call always writes its link register, so it takes the WRITEBACK path
    // even if the decoder leaves IsWb clear.
    assign w_to_wb  = w_is_wb | w_is_call;
    assign w_to_mem = w_is_ld | w_is_st;

    // Branches look only at the flags left by an earlier cmp, never at the live ALU compare.
    assign w_taken = w_is_ubr | (w_is_beq & r_flag_e) | (w_is_bgt & r_flag_gt);

    // Retire happens in whichever state hands control back to FETCH.
    assign w_retire = ((r_state == S_EXECUTE) && !w_to_mem && !w_to_wb)
                    || ((r_state == S_MEMORY) && bus.MemAck && !w_is_ld)
                    || (r_state == S_WRITEBACK);

    // Fires on the cycle whose miss would make the wait count reach TIMEOUT.
    assign w_wait_hit = (({1'b0, r_wait} + 5'd1) >= TIMEOUT_LIM);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_wait      <= '0;
            r_flag_e    <= 1'b0;
            r_flag_gt   <= 1'b0;
            r_error     <= 1'b0;
            r_instr_cnt <= '0;
        end else begin
            // The wait counter only survives a cycle spent stalled in FETCH/MEMORY,
            // so every entry into those states starts from zero.
            r_wait <= '0;
            if (w_retire) begin
                r_instr_cnt <= r_instr_cnt + CNT_W'(1);
            end
            case (r_state)
                S_IDLE: begin
                    if (bus.Start) begin
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (bus.MemAck) begin
                        r_state <= S_DECODE;
                    end else if (w_wait_hit) begin
                        r_state <= S_HALT;
                        r_error <= 1'b1;
                    end else begin
                        r_wait <= r_wait + 4'd1;
                    end
                end
                S_DECODE: begin
                    if (bus.Opcode >= OP_FIRST_BAD) begin
                        r_state <= S_HALT;
                        r_error <= 1'b1;
                    end else begin
                        r_state <= S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    if (bus.Opcode == OP_CMP) begin
                        r_flag_e  <= bus.AluEq;
                        r_flag_gt <= bus.AluGt;
                    end
                    if (w_to_mem) begin
                        r_state <= S_MEMORY;
                    end else if (w_to_wb) begin
                        r_state <= S_WRITEBACK;
                    end else begin
                        r_state <= S_FETCH;
                    end
                end
                S_MEMORY: begin
                    if (bus.MemAck) begin
                        r_state <= w_is_ld ? S_WRITEBACK : S_FETCH;
                    end else if (w_wait_hit) begin
                        r_state <= S_HALT;
                        r_error <= 1'b1;
                    end else begin
                        r_wait <= r_wait + 4'd1;
                    end
                end
                S_WRITEBACK: begin
                    r_state <= S_FETCH;
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    // Illegal encoding: park in HALT and flag it.
                    r_state <= S_HALT;
                    r_error <= 1'b1;
                end
            endcase
        end
    end

    // Strobes decode from the registered state, so reset clears them
    // asynchronously together with the state register.
    always_comb begin
        bus.MemReq   = 1'b0;
        bus.MemWe    = 1'b0;
        bus.IrWrite  = 1'b0;
        bus.RegWrite = 1'b0;
        case (r_state)
            S_FETCH: begin
                bus.MemReq  = 1'b1;
                bus.IrWrite = bus.MemAck;
            end
            S_MEMORY: begin
                bus.MemReq = 1'b1;
                bus.MemWe  = w_is_st;
            end
            S_WRITEBACK: begin
                bus.RegWrite = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        bus.PcSel = 2'b00;
        if (w_retire) begin
            if (w_is_ret) begin
                bus.PcSel = 2'b10;
            end else if (w_taken) begin
                bus.PcSel = 2'b01;
            end
        end
    end

    assign bus.PcWrite    = w_retire;
    assign bus.State      = r_state;
    assign bus.Halted     = (r_state == S_HALT);
    assign bus.Error      = r_error;
    assign bus.InstrCount = r_instr_cnt;

endmodule

// File: tb/tb_multicycle_sequencer.sv
module tb_multicycle_sequencer;

    logic clk;
    logic reset_n;

    multicycle_sequencer_if #(.CNT_W(32)) bus ();

    multicycle_sequencer #(.TIMEOUT(15), .CNT_W(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] op;
        logic [7:0] dec;
        logic       eq;
        logic       gt;
        int         fw;        // FETCH cycles without ack before the ack cycle
        int         mw;        // MEMORY cycles without ack before the ack cycle
        logic       exp_mem;
        logic       exp_we;
        logic       exp_wb;
        logic [1:0] exp_pcsel;
    } vec_t;

    typedef struct {
        logic [1:0]  pcsel;
        logic        regwr;
        logic [31:0] cnt;
    } sb_t;

    vec_t        tbl [17];
    sb_t         sb [$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_count = 0;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s (vec %0d): got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every retire must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset_n && bus.PcWrite) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_unexpected_retire: got PcWrite=1, expected no retire");
            end else begin
                sb_t e;
                e = sb.pop_front();
                chk("sb_pcsel",    -1, 32'(bus.PcSel),    32'(e.pcsel));
                chk("sb_regwrite", -1, 32'(bus.RegWrite), 32'(e.regwr));
                chk("sb_count",    -1, bus.InstrCount,    e.cnt);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 100000ns");
        $fatal(1);
    end

    task automatic start_fetch();
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
    endtask

    task automatic reset_pulse();
        reset_n = 1'b0;
        #1;
        chk("rst_state", -1, 32'(bus.State),  32'd0);
        chk("rst_error", -1, 32'(bus.Error),  32'd0);
        chk("rst_halt",  -1, 32'(bus.Halted), 32'd0);
        tick();
        reset_n   = 1'b1;
        exp_count = 0;
    endtask

    // Runs one instruction starting in FETCH; ends back in FETCH.
    task automatic do_instr(input vec_t v, input int idx);
        sb_t e;
        bus.Opcode    = v.op;
        bus.DecodeBus = v.dec;
        bus.AluEq     = v.eq;
        bus.AluGt     = v.gt;
        bus.MemAck    = 1'b0;
        e.pcsel = v.exp_pcsel;
        e.regwr = v.exp_wb;
        e.cnt   = exp_count;
        sb.push_back(e);
        for (int i = 0; i < v.fw; i++) begin
            #1;
            chk("fetch_wait_state", idx, 32'(bus.State),   32'd1);
            chk("fetch_wait_req",   idx, 32'(bus.MemReq),  32'd1);
            chk("fetch_wait_ir",    idx, 32'(bus.IrWrite), 32'd0);
            tick();
        end
        bus.MemAck = 1'b1;
        #1;
        chk("fetch_ack_state", idx, 32'(bus.State),   32'd1);
        chk("fetch_ack_ir",    idx, 32'(bus.IrWrite), 32'd1);
        chk("fetch_ack_we",    idx, 32'(bus.MemWe),   32'd0);
        tick();
        bus.MemAck = 1'b0;
        #1;
        chk("decode_state", idx, 32'(bus.State),   32'd2);
        chk("decode_pcw",   idx, 32'(bus.PcWrite), 32'd0);
        tick();
        #1;
        chk("exec_state", idx, 32'(bus.State),   32'd3);
        chk("exec_req",   idx, 32'(bus.MemReq),  32'd0);
        chk("exec_pcw",   idx, 32'(bus.PcWrite), 32'(!(v.exp_mem || v.exp_wb)));
        tick();
        if (v.exp_mem) begin
            for (int i = 0; i < v.mw; i++) begin
                #1;
                chk("mem_wait_state", idx, 32'(bus.State),   32'd4);
                chk("mem_wait_req",   idx, 32'(bus.MemReq),  32'd1);
                chk("mem_wait_we",    idx, 32'(bus.MemWe),   32'(v.exp_we));
                chk("mem_wait_pcw",   idx, 32'(bus.PcWrite), 32'd0);
                tick();
            end
            bus.MemAck = 1'b1;
            #1;
            chk("mem_ack_we",  idx, 32'(bus.MemWe),    32'(v.exp_we));
            chk("mem_ack_pcw", idx, 32'(bus.PcWrite),  32'(!v.exp_wb));
            chk("mem_ack_rw",  idx, 32'(bus.RegWrite), 32'd0);
            tick();
            bus.MemAck = 1'b0;
        end
        if (v.exp_wb) begin
            #1;
            chk("wb_state", idx, 32'(bus.State),    32'd5);
            chk("wb_rw",    idx, 32'(bus.RegWrite), 32'd1);
            chk("wb_pcw",   idx, 32'(bus.PcWrite),  32'd1);
            tick();
        end
        exp_count = exp_count + 1;
        #1;
        chk("retire_state", idx, 32'(bus.State),  32'd1);
        chk("retire_count", idx, bus.InstrCount,  exp_count);
        chk("retire_sb",    idx, 32'(sb.size()),  32'd0);
        chk("retire_error", idx, 32'(bus.Error),  32'd0);
    endtask

    initial begin
        reset_n       = 1'b0;
        bus.Start     = 1'b0;
        bus.Opcode    = '0;
        bus.DecodeBus = '0;
        bus.AluEq     = 1'b0;
        bus.AluGt     = 1'b0;
        bus.MemAck    = 1'b0;

        //            op        dec    eq    gt    fw  mw  mem   we    wb    pcsel
        tbl[0]  = '{5'b00000, 8'h80, 1'b0, 1'b0,  2,  0, 1'b0, 1'b0, 1'b1, 2'b00}; // add
        tbl[1]  = '{5'b00001, 8'h02, 1'b0, 1'b0,  0,  2, 1'b1, 1'b0, 1'b1, 2'b00}; // ld
        tbl[2]  = '{5'b00010, 8'h01, 1'b0, 1'b0,  1,  2, 1'b1, 1'b1, 1'b0, 2'b00}; // st
        tbl[3]  = '{5'b00101, 8'h00, 1'b1, 1'b0,  0,  0, 1'b0, 1'b0, 1'b0, 2'b00}; // cmp eq
        tbl[4]  = '{5'b00110, 8'h04, 1'b0, 1'b1,  0,  0, 1'b0, 1'b0, 1'b0, 2'b01}; // beq taken
        tbl[5]  = '{5'b00111, 8'h08, 1'b0, 1'b1,  0,  0, 1'b0, 1'b0, 1'b0, 2'b00}; // bgt not taken
        tbl[6]  = '{5'b00101, 8'h00, 1'b0, 1'b1,  0,  0, 1'b0, 1'b0, 1'b0, 2'b00}; // cmp gt
        tbl[7]  = '{5'b00110, 8'h04, 1'b1, 1'b0,  0,  0, 1'b0, 1'b0, 1'b0, 2'b00}; // beq not taken
        tbl[8]  = '{5'b00111, 8'h08, 1'b0, 1'b0,  0,  0, 1'b0, 1'b0, 1'b0, 2'b01}; // bgt taken
        tbl[9]  = '{5'b01000, 8'hE0, 1'b0, 1'b0,  0,  0, 1'b0, 1'b0, 1'b1, 2'b01}; // call
        tbl[10] = '{5'b01001, 8'h10, 1'b0, 1'b0,  0,  0, 1'b0, 1'b0, 1'b0, 2'b10}; // ret
        tbl[11] = '{5'b01010, 8'h20, 1'b0, 1'b0,  0,  0, 1'b0, 1'b0, 1'b0, 2'b01}; // jmp
        tbl[12] = '{5'b00000, 8'h80, 1'b1, 1'b0, 14,  0, 1'b0, 1'b0, 1'b1, 2'b00}; // add, ack on 15th cycle
        tbl[13] = '{5'b00110, 8'h04, 1'b0, 1'b0,  0,  0, 1'b0, 1'b0, 1'b0, 2'b00}; // beq, flags untouched by add
        tbl[14] = '{5'b00111, 8'h08, 1'b0, 1'b0,  0,  0, 1'b0, 1'b0, 1'b0, 2'b01}; // bgt still taken
        tbl[15] = '{5'b10100, 8'h00, 1'b0, 1'b0,  0,  0, 1'b0, 1'b0, 1'b0, 2'b00}; // last legal opcode
        tbl[16] = '{5'b00010, 8'h01, 1'b0, 1'b0,  0, 14, 1'b1, 1'b1, 1'b0, 2'b00}; // st, ack on 15th cycle

        repeat (2) @(posedge clk);
        #1;
        chk("reset_state",  -1, 32'(bus.State),    32'd0);
        chk("reset_req",    -1, 32'(bus.MemReq),   32'd0);
        chk("reset_ir",     -1, 32'(bus.IrWrite),  32'd0);
        chk("reset_pcw",    -1, 32'(bus.PcWrite),  32'd0);
        chk("reset_rw",     -1, 32'(bus.RegWrite), 32'd0);
        chk("reset_pcsel",  -1, 32'(bus.PcSel),    32'd0);
        chk("reset_halted", -1, 32'(bus.Halted),   32'd0);
        chk("reset_error",  -1, 32'(bus.Error),    32'd0);
        chk("reset_count",  -1, bus.InstrCount,    32'd0);
        reset_n = 1'b1;

        // IDLE holds without Start and ignores MemAck.
        bus.MemAck = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            #1;
            chk("idle_state", -1, 32'(bus.State),   32'd0);
            chk("idle_req",   -1, 32'(bus.MemReq),  32'd0);
            chk("idle_ir",    -1, 32'(bus.IrWrite), 32'd0);
        end
        bus.MemAck = 1'b0;
        start_fetch();

        for (int i = 0; i < 17; i++) begin
            do_instr(tbl[i], i);
        end

        // FETCH timeout: 15 cycles without ack.
        bus.MemAck = 1'b0;
        for (int i = 0; i < 15; i++) begin
            #1;
            chk("to_fetch_state", -1, 32'(bus.State),  32'd1);
            chk("to_fetch_req",   -1, 32'(bus.MemReq), 32'd1);
            tick();
        end
        #1;
        chk("to_halt_state", -1, 32'(bus.State),  32'd6);
        chk("to_halted",     -1, 32'(bus.Halted), 32'd1);
        chk("to_error",      -1, 32'(bus.Error),  32'd1);
        chk("to_req",        -1, 32'(bus.MemReq), 32'd0);
        bus.Start  = 1'b1;
        bus.MemAck = 1'b1;
        tick();
        tick();
        #1;
        chk("halt_start_state", -1, 32'(bus.State),   32'd6);
        chk("halt_ir",          -1, 32'(bus.IrWrite), 32'd0);
        chk("halt_pcw",         -1, 32'(bus.PcWrite), 32'd0);
        chk("halt_error",       -1, 32'(bus.Error),   32'd1);
        bus.Start  = 1'b0;
        bus.MemAck = 1'b0;
        reset_pulse();

        // Illegal opcode halts from DECODE.
        start_fetch();
        bus.Opcode    = 5'b10110;
        bus.DecodeBus = 8'h00;
        bus.MemAck    = 1'b1;
        #1;
        chk("bad_ir", -1, 32'(bus.IrWrite), 32'd1);
        tick();
        bus.MemAck = 1'b0;
        #1;
        chk("bad_decode_state", -1, 32'(bus.State), 32'd2);
        tick();
        #1;
        chk("bad_halt_state", -1, 32'(bus.State),   32'd6);
        chk("bad_error",      -1, 32'(bus.Error),   32'd1);
        chk("bad_halted",     -1, 32'(bus.Halted),  32'd1);
        chk("bad_pcw",        -1, 32'(bus.PcWrite), 32'd0);
        tick();
        tick();
        #1;
        chk("bad_error_sticky", -1, 32'(bus.Error), 32'd1);
        chk("bad_count",        -1, bus.InstrCount, 32'd0);
        reset_pulse();

        // Reset in the middle of a MEMORY wait.
        start_fetch();
        do_instr(tbl[0], 100);
        bus.Opcode    = 5'b00001;
        bus.DecodeBus = 8'h02;
        bus.MemAck    = 1'b1;
        #1;
        tick();
        bus.MemAck = 1'b0;
        tick();
        tick();
        #1;
        chk("mid_mem_state", -1, 32'(bus.State),  32'd4);
        chk("mid_mem_req",   -1, 32'(bus.MemReq), 32'd1);
        chk("mid_mem_count", -1, bus.InstrCount,  32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_state", -1, 32'(bus.State),  32'd0);
        chk("mid_rst_req",   -1, 32'(bus.MemReq), 32'd0);
        chk("mid_rst_count", -1, bus.InstrCount,  32'd0);
        tick();
        reset_n   = 1'b1;
        exp_count = 0;
        tick();
        #1;
        chk("post_rst_state", -1, 32'(bus.State), 32'd0);
        chk("final_sb",       -1, 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
